sopc_input_pio: RTL and testbench



---
 rtl/sopc_input_pio.sv | 135 +++++++++++++
 tb/tb_sopc_input_pio.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sopc_input_pio.sv
// Avalon-MM parallel-input PIO: synchronized inputs, per-bit edge capture, masked level IRQ.
// Optional per-bit debounce is compiled in with `define SOPC_INPUT_PIO_DEBOUNCE_EN.
module sopc_input_pio #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned DW = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
    localparam logic [1:0] ARM_DONE     = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_level_d;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [1:0]       r_arm;

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_armed;
    logic             w_unused;

    // Two-flop synchronizer and one-cycle delayed level for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_level_d <= '0;
        end else begin
            r_s1      <= in_port;
            r_s2      <= r_s1;
            r_level_d <= w_level;
        end
    end

`ifdef SOPC_INPUT_PIO_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_level;

    // A bit's new value is accepted only after it has differed from level for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (r_s2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_level[i] <= r_s2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_s2;
`endif

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_level & ~r_level_d;
            1:       w_edge = ~w_level & r_level_d;
            default: w_edge = w_level ^ r_level_d;
        endcase
    end

    assign w_wr    = chipselect && !write_n;
    assign w_clr   = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
    assign w_armed = (r_arm == ARM_DONE);

    // Capture stays off until the synchronizer has filled after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm <= '0;
        end else if (!w_armed) begin
            r_arm <= r_arm + 2'd1;
        end
    end

    // Set has priority over a same-cycle write-1-to-clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
            r_irqmask <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | (w_armed ? w_edge : '0);
            if (w_wr && (address == ADDR_IRQMASK)) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = DW'(w_level);
            ADDR_IRQMASK: readdata = DW'(r_irqmask);
            ADDR_EDGECAP: readdata = DW'(r_edgecap);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(r_edgecap & r_irqmask);

    assign w_unused = ^{writedata, DW'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_sopc_input_pio.sv
// Directed self-checking bench for sopc_input_pio (WIDTH=2, falling-edge capture).
module tb_sopc_input_pio;

    localparam int unsigned WIDTH = 2;
`ifdef SOPC_INPUT_PIO_DEBOUNCE_EN
    localparam int SETTLE = 10;
`else
    localparam int SETTLE = 3;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rv;

    sopc_input_pio #(
        .WIDTH(WIDTH),
        .EDGE_TYPE(1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One write strobe spanning exactly one rising edge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        address    = 2'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
        address    = 2'd0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 2'b11;
        tick(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);

        reset_n = 1'b1;
        tick(SETTLE);
        bus_read(2'd0, rv); check("post_reset_data", rv, 32'h3);
        bus_read(2'd3, rv); check("post_reset_edgecap", rv, 32'h0);

        // Writes to DATA and reserved are ignored; IRQMASK keeps only WIDTH bits
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd0, rv); check("data_after_ro_write", rv, 32'h3);
        bus_read(2'd1, rv); check("reserved_read", rv, 32'h0);
        bus_read(2'd2, rv); check("mask_untouched", rv, 32'h0);
        bus_read(2'd3, rv); check("edgecap_untouched", rv, 32'h0);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, rv); check("mask_all_ones", rv, 32'h3);
        check("irq_no_capture", {31'b0, irq}, 32'h0);

`ifdef SOPC_INPUT_PIO_DEBOUNCE_EN
        // Short glitch rejected
        in_port = 2'b10;
        tick(3);
        in_port = 2'b11;
        tick(10);
        bus_read(2'd0, rv); check("glitch_data", rv, 32'h3);
        bus_read(2'd3, rv); check("glitch_edgecap", rv, 32'h0);
        // Long low accepted after the debounce interval
        in_port = 2'b10;
        tick(4);
        bus_read(2'd0, rv); check("debounce_pending", rv, 32'h3);
        tick(6);
        bus_read(2'd0, rv); check("debounce_data", rv, 32'h2);
        bus_read(2'd3, rv); check("debounce_edgecap", rv, 32'h1);
        check("debounce_irq", {31'b0, irq}, 32'h1);
`else
        bus_write(2'd2, 32'h1);
        // Falling edge on bit 0: s1 at k, DATA at k+1, capture at k+2
        in_port = 2'b10;
        tick(1);
        bus_read(2'd0, rv); check("fall_data_k", rv, 32'h3);
        tick(1);
        bus_read(2'd0, rv); check("fall_data_k1", rv, 32'h2);
        bus_read(2'd3, rv); check("fall_edgecap_k1", rv, 32'h0);
        check("fall_irq_k1", {31'b0, irq}, 32'h0);
        tick(1);
        bus_read(2'd3, rv); check("fall_edgecap_k2", rv, 32'h1);
        check("fall_irq_k2", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rv); check("clear_edgecap", rv, 32'h0);
        check("clear_irq", {31'b0, irq}, 32'h0);

        // Bit 1 capture masked out, then unmasked
        in_port = 2'b00;
        tick(3);
        bus_read(2'd3, rv); check("mask_edgecap", rv, 32'h2);
        check("masked_irq", {31'b0, irq}, 32'h0);
        bus_write(2'd2, 32'h3);
        check("unmasked_irq", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h3);
        check("clear_all_irq", {31'b0, irq}, 32'h0);

        // Rising edge is not captured in falling mode
        in_port = 2'b01;
        tick(3);
        bus_read(2'd3, rv); check("rising_ignored", rv, 32'h0);

        // Falling edge set lands on the same edge as a clear write: set wins
        in_port = 2'b00;
        tick(2);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rv); check("set_beats_clear", rv, 32'h1);
        check("collision_irq", {31'b0, irq}, 32'h1);
`endif

        // Asynchronous reset mid-operation clears everything immediately
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd2, rv); check("midreset_mask", rv, 32'h0);
        bus_read(2'd3, rv); check("midreset_edgecap", rv, 32'h0);
        bus_read(2'd0, rv); check("midreset_data", rv, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(SETTLE + 2);
        bus_read(2'd3, rv); check("rearm_edgecap", rv, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
